// File: rtl/axi4_bridge_pkg.sv
// Shared types and constants for the LSU-to-AXI4 bridge.
// Holds the bus widths, the word-alignment mask and the bridge FSM encoding.
package axi4_bridge_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [AXI_ADDR_W-1:0] WORD_ALIGN_MASK = {{(AXI_ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_e;

    function automatic logic [AXI_ADDR_W-1:0] word_align(input logic [AXI_ADDR_W-1:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/axi4_lsu_master_if.sv
// LSU request/response port plus AXI4 master channels, bundled as one interface.
// The master modport is the bridge's view; slave is the view of the LSU/RAM side.
interface axi4_lsu_master_if;
    import axi4_bridge_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [AXI_ADDR_W-1:0] req_addr;
    logic [AXI_DATA_W-1:0] req_wdata;
    logic [AXI_STRB_W-1:0] req_wstrb;
    logic                  resp_valid;
    logic [AXI_DATA_W-1:0] resp_rdata;
    logic                  resp_err;

    logic [AXI_ADDR_W-1:0] m_axi_araddr;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [AXI_DATA_W-1:0] m_axi_rdata;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [AXI_ADDR_W-1:0] m_axi_awaddr;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [AXI_DATA_W-1:0] m_axi_wdata;
    logic [AXI_STRB_W-1:0] m_axi_wstrb;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
        input  m_axi_arready, m_axi_rdata, m_axi_rvalid,
        input  m_axi_awready, m_axi_wready, m_axi_bvalid
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
        output m_axi_arready, m_axi_rdata, m_axi_rvalid,
        output m_axi_awready, m_axi_wready, m_axi_bvalid
    );

endinterface

// File: rtl/axi4_lsu_master.sv
// Single-outstanding bridge turning one LSU word load/store into an AXI4 transaction.
// A per-state watchdog converts a stalled channel into an error response.
module axi4_lsu_master
    import axi4_bridge_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi4_lsu_master_if.master     bus
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [7:0]            r_wd_cnt;
    logic                  r_arvalid;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [AXI_DATA_W-1:0] r_resp_rdata;
    logic [AXI_ADDR_W-1:0] r_araddr;
    logic [AXI_ADDR_W-1:0] r_awaddr;
    logic [AXI_DATA_W-1:0] r_wdata;
    logic [AXI_STRB_W-1:0] r_wstrb;

    logic w_accept;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_wr_done;
    logic w_progress;
    logic w_timeout;

    assign w_accept  = bus.req_valid && (r_state == ST_IDLE);
    assign w_ar_hs   = r_arvalid && bus.m_axi_arready;
    assign w_r_hs    = (r_state == ST_RD_DATA) && bus.m_axi_rvalid;
    assign w_aw_hs   = r_awvalid && bus.m_axi_awready;
    assign w_w_hs    = r_wvalid && bus.m_axi_wready;
    assign w_b_hs    = (r_state == ST_WR_RESP) && bus.m_axi_bvalid;
    // A channel whose valid already dropped has completed its handshake.
    assign w_wr_done = (!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can infer a latch.
        w_state_nxt = r_state;
        w_progress  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = bus.req_we ? ST_WR_REQ : ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                w_progress = w_ar_hs;
                if (w_ar_hs) w_state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                w_progress = w_r_hs;
                if (w_r_hs) w_state_nxt = ST_IDLE;
            end
            ST_WR_REQ: begin
                w_progress = w_aw_hs || w_w_hs;
                if (w_wr_done) w_state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                w_progress = w_b_hs;
                if (w_b_hs) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Progress on the expiry cycle wins over the timeout.
        w_timeout = (r_state != ST_IDLE) && !w_progress && (r_wd_cnt == TIMEOUT_CYCLES);
        if (w_timeout) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_wd_cnt     <= 8'd0;
            r_arvalid    <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_state_nxt != r_state)
                r_wd_cnt <= 8'd0;
            else if ((r_state != ST_IDLE) && !w_progress)
                r_wd_cnt <= r_wd_cnt + 8'd1;

            if (w_timeout || w_ar_hs)        r_arvalid <= 1'b0;
            else if (w_accept && !bus.req_we) r_arvalid <= 1'b1;

            if (w_timeout || w_aw_hs)        r_awvalid <= 1'b0;
            else if (w_accept && bus.req_we)  r_awvalid <= 1'b1;

            if (w_timeout || w_w_hs)         r_wvalid <= 1'b0;
            else if (w_accept && bus.req_we)  r_wvalid <= 1'b1;

            r_resp_valid <= w_r_hs || w_b_hs || w_timeout;
            r_resp_err   <= w_timeout;
            if (w_timeout)   r_resp_rdata <= '0;
            else if (w_r_hs) r_resp_rdata <= bus.m_axi_rdata;
        end
    end

    // Payload registers only load on acceptance, so they stay stable while valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_araddr <= '0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_accept) begin
            if (bus.req_we) begin
                r_awaddr <= word_align(bus.req_addr);
                r_wdata  <= bus.req_wdata;
                r_wstrb  <= bus.req_wstrb;
            end else begin
                r_araddr <= word_align(bus.req_addr);
            end
        end
    end

    assign bus.req_ready     = (r_state == ST_IDLE);
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_rdata    = r_resp_rdata;
    assign bus.resp_err      = r_resp_err;
    assign bus.m_axi_araddr  = r_araddr;
    assign bus.m_axi_arvalid = r_arvalid;
    assign bus.m_axi_rready  = (r_state == ST_RD_DATA);
    assign bus.m_axi_awaddr  = r_awaddr;
    assign bus.m_axi_awvalid = r_awvalid;
    assign bus.m_axi_wdata   = r_wdata;
    assign bus.m_axi_wstrb   = r_wstrb;
    assign bus.m_axi_wvalid  = r_wvalid;
    assign bus.m_axi_bready  = (r_state == ST_WR_RESP);

endmodule

// File: tb/tb_axi4_lsu_master.sv
// Directed bench: DUT A runs against a latency-L RAM slave model, DUT B (timeout 10)
// is driven by hand to exercise the watchdog and its expiry boundary.
module tb_axi4_lsu_master;
    import axi4_bridge_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_lsu_master_if bus_a ();
    axi4_lsu_master_if bus_b ();

    axi4_lsu_master u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    axi4_lsu_master #(.TIMEOUT_CYCLES(8'd10)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int overlap_cnt = 0;
    int a_resp_cnt  = 0;
    int lat = 20;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus_a.m_axi_arvalid && bus_a.m_axi_awvalid) overlap_cnt++;
        if (bus_a.resp_valid) a_resp_cnt++;
    end

    // RAM slave for DUT A: rvalid rises L+1 edges after the AR handshake,
    // bvalid rises L+2 edges after the later of the AW/W handshakes.
    logic [31:0] mem [0:255];
    logic        s_rd_pend, s_aw_got, s_w_got, s_wr_pend;
    int          s_rd_cnt, s_wr_cnt;
    logic [31:0] s_araddr_q, s_awaddr_q, s_wdata_q;
    logic [3:0]  s_wstrb_q;

    always @(posedge clk or negedge rst_n) begin : ram_slave
        logic        aw_now, w_now;
        logic [31:0] wa, wd, merged;
        logic [3:0]  ws;
        if (!rst_n) begin
            bus_a.m_axi_rvalid <= 1'b0;
            bus_a.m_axi_rdata  <= 32'h0;
            bus_a.m_axi_bvalid <= 1'b0;
            s_rd_pend <= 1'b0;
            s_wr_pend <= 1'b0;
            s_aw_got  <= 1'b0;
            s_w_got   <= 1'b0;
            s_rd_cnt  <= 0;
            s_wr_cnt  <= 0;
            s_araddr_q <= 32'h0;
            s_awaddr_q <= 32'h0;
            s_wdata_q  <= 32'h0;
            s_wstrb_q  <= 4'h0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4] <= 32'hDEAD_BEEF;
        end else begin
            aw_now = bus_a.m_axi_awvalid && bus_a.m_axi_awready;
            w_now  = bus_a.m_axi_wvalid && bus_a.m_axi_wready;

            if (bus_a.m_axi_rvalid && bus_a.m_axi_rready) bus_a.m_axi_rvalid <= 1'b0;
            if (bus_a.m_axi_arvalid && bus_a.m_axi_arready) begin
                s_rd_pend  <= 1'b1;
                s_rd_cnt   <= lat;
                s_araddr_q <= bus_a.m_axi_araddr;
            end else if (s_rd_pend) begin
                if (s_rd_cnt == 0) begin
                    bus_a.m_axi_rvalid <= 1'b1;
                    bus_a.m_axi_rdata  <= mem[s_araddr_q[9:2]];
                    s_rd_pend <= 1'b0;
                end else begin
                    s_rd_cnt <= s_rd_cnt - 1;
                end
            end

            wa = aw_now ? bus_a.m_axi_awaddr : s_awaddr_q;
            wd = w_now  ? bus_a.m_axi_wdata  : s_wdata_q;
            ws = w_now  ? bus_a.m_axi_wstrb  : s_wstrb_q;
            if (aw_now) s_awaddr_q <= bus_a.m_axi_awaddr;
            if (w_now) begin
                s_wdata_q <= bus_a.m_axi_wdata;
                s_wstrb_q <= bus_a.m_axi_wstrb;
            end
            if ((s_aw_got || aw_now) && (s_w_got || w_now)) begin
                merged = mem[wa[9:2]];
                for (int b = 0; b < 4; b++)
                    if (ws[b]) merged[8*b +: 8] = wd[8*b +: 8];
                mem[wa[9:2]] <= merged;
                s_aw_got  <= 1'b0;
                s_w_got   <= 1'b0;
                s_wr_pend <= 1'b1;
                s_wr_cnt  <= lat + 1;
            end else begin
                if (aw_now) s_aw_got <= 1'b1;
                if (w_now)  s_w_got  <= 1'b1;
            end

            if (bus_a.m_axi_bvalid && bus_a.m_axi_bready) bus_a.m_axi_bvalid <= 1'b0;
            if (s_wr_pend) begin
                if (s_wr_cnt == 0) begin
                    bus_a.m_axi_bvalid <= 1'b1;
                    s_wr_pend <= 1'b0;
                end else begin
                    s_wr_cnt <= s_wr_cnt - 1;
                end
            end
        end
    end

    // Presents a request to DUT A and returns just after its acceptance edge (edge 0).
    task automatic a_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic keep, output logic acc_in_resp);
        int n;
        bus_a.req_we    = we;
        bus_a.req_addr  = addr;
        bus_a.req_wdata = wdata;
        bus_a.req_wstrb = strb;
        bus_a.req_valid = 1'b1;
        n = 0;
        while (!bus_a.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("a_accept", bus_a.req_ready, 1'b1);
        acc_in_resp = bus_a.resp_valid;
        @(posedge clk);
        #1;
        if (!keep) bus_a.req_valid = 1'b0;
    endtask

    // Counts edges after edge 'start' until resp_valid is seen; returns at that negedge.
    task automatic a_wait_resp(input int start, output int edges, output logic [31:0] rd,
                               output logic err);
        edges = -1;
        rd    = 32'h0;
        err   = 1'b0;
        for (int n = start + 1; n <= start + 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_a.resp_valid) begin
                edges = n;
                rd    = bus_a.resp_rdata;
                err   = bus_a.resp_err;
                break;
            end
        end
    endtask

    // Load on DUT B; arready rises in time for edge 'ar_edge' (0 = never).
    task automatic b_load(input logic [31:0] addr, input int ar_edge, output int edges,
                          output logic [31:0] rd, output logic err, output logic [31:0] aseen);
        int n;
        bus_b.m_axi_arready = (ar_edge == 1);
        bus_b.req_we    = 1'b0;
        bus_b.req_addr  = addr;
        bus_b.req_valid = 1'b1;
        n = 0;
        while (!bus_b.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_accept", bus_b.req_ready, 1'b1);
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
        aseen = bus_b.m_axi_araddr;
        edges = -1;
        rd    = 32'h0;
        err   = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_b.resp_valid) begin
                edges = i;
                rd    = bus_b.resp_rdata;
                err   = bus_b.resp_err;
                break;
            end
            if (i + 1 == ar_edge) bus_b.m_axi_arready = 1'b1;
        end
        bus_b.m_axi_arready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          e;
        logic [31:0] rd, aseen;
        logic        er, acc;
        int          base;

        bus_a.req_valid = 1'b0;  bus_a.req_we = 1'b0;   bus_a.req_addr = 32'h0;
        bus_a.req_wdata = 32'h0; bus_a.req_wstrb = 4'h0;
        bus_a.m_axi_arready = 1'b1; bus_a.m_axi_awready = 1'b1; bus_a.m_axi_wready = 1'b1;
        bus_b.req_valid = 1'b0;  bus_b.req_we = 1'b0;   bus_b.req_addr = 32'h0;
        bus_b.req_wdata = 32'h0; bus_b.req_wstrb = 4'h0;
        bus_b.m_axi_arready = 1'b0; bus_b.m_axi_rvalid = 1'b1; bus_b.m_axi_rdata = 32'h1234_5678;
        bus_b.m_axi_awready = 1'b0; bus_b.m_axi_wready = 1'b0; bus_b.m_axi_bvalid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  bus_a.req_ready, 1'b1);
        check("rst_arvalid",    bus_a.m_axi_arvalid, 1'b0);
        check("rst_awvalid",    bus_a.m_axi_awvalid, 1'b0);
        check("rst_wvalid",     bus_a.m_axi_wvalid, 1'b0);
        check("rst_rready",     bus_a.m_axi_rready, 1'b0);
        check("rst_bready",     bus_a.m_axi_bready, 1'b0);
        check("rst_resp_valid", bus_a.resp_valid, 1'b0);
        check("rst_resp_rdata", bus_a.resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Load, L = 20
        lat = 20;
        a_issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, acc);
        a_wait_resp(0, e, rd, er);
        check("ld_edge",  e, 23);
        check("ld_rdata", rd, 32'hDEAD_BEEF);
        check("ld_err",   er, 1'b0);
        @(negedge clk);
        check("ld_pulse_once", bus_a.resp_valid, 1'b0);
        check("ld_rdata_hold", bus_a.resp_rdata, 32'hDEAD_BEEF);

        // Partial store then read-back
        a_issue(1'b1, 32'h20, 32'hA5A5_1234, 4'b0011, 1'b0, acc);
        a_wait_resp(0, e, rd, er);
        check("st_edge", e, 24);
        check("st_err",  er, 1'b0);
        @(negedge clk);
        check("st_pulse_once", bus_a.resp_valid, 1'b0);
        a_issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, acc);
        a_wait_resp(0, e, rd, er);
        check("st_ld_edge",  e, 23);
        check("st_ld_rdata", rd, 32'h0000_1234);
        @(negedge clk);

        // W completes first, AW stalled for 5 cycles
        lat = 2;
        bus_a.m_axi_awready = 1'b0;
        a_issue(1'b1, 32'h44, 32'hCAFE_F00D, 4'hF, 1'b0, acc);
        check("stall_aw_up", bus_a.m_axi_awvalid, 1'b1);
        check("stall_w_up",  bus_a.m_axi_wvalid, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("stall_w_dropped", bus_a.m_axi_wvalid, 1'b0);
        check("stall_aw_held1",  bus_a.m_axi_awvalid, 1'b1);
        check("stall_awaddr1",   bus_a.m_axi_awaddr, 32'h44);
        repeat (4) @(negedge clk);
        check("stall_aw_held5",  bus_a.m_axi_awvalid, 1'b1);
        check("stall_awaddr5",   bus_a.m_axi_awaddr, 32'h44);
        check("stall_w_stays0",  bus_a.m_axi_wvalid, 1'b0);
        check("stall_no_bready", bus_a.m_axi_bready, 1'b0);
        bus_a.m_axi_awready = 1'b1;
        a_wait_resp(5, e, rd, er);
        check("stall_edge", e, 11);
        check("stall_err",  er, 1'b0);
        check("stall_mem",  mem[17], 32'hCAFE_F00D);
        @(negedge clk);
        check("stall_pulse_once", bus_a.resp_valid, 1'b0);

        // DUT B: normal load, timeout, and handshake on the expiry cycle
        b_load(32'h13, 1, e, rd, er, aseen);
        check("b_araddr_align", aseen, 32'h10);
        check("b_ok_edge",  e, 2);
        check("b_ok_rdata", rd, 32'h1234_5678);
        check("b_ok_err",   er, 1'b0);
        @(negedge clk);
        b_load(32'h28, 0, e, rd, er, aseen);
        check("b_to_edge",    e, 11);
        check("b_to_err",     er, 1'b1);
        check("b_to_rdata",   rd, 32'h0);
        check("b_to_arvalid", bus_b.m_axi_arvalid, 1'b0);
        check("b_to_ready",   bus_b.req_ready, 1'b1);
        @(negedge clk);
        check("b_to_pulse_once", bus_b.resp_valid, 1'b0);
        b_load(32'h30, 11, e, rd, er, aseen);
        check("b_edge_hs_edge",  e, 12);
        check("b_edge_hs_err",   er, 1'b0);
        check("b_edge_hs_rdata", rd, 32'h1234_5678);
        @(negedge clk);

        // Back-to-back load, store, load with req_valid held
        lat = 1;
        a_issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, acc);
        a_wait_resp(0, e, rd, er);
        check("b2b_ld1_edge",  e, 4);
        check("b2b_ld1_rdata", rd, 32'hDEAD_BEEF);
        a_issue(1'b1, 32'h30, 32'h1111_2222, 4'hF, 1'b1, acc);
        check("b2b_st_acc_in_resp", acc, 1'b1);
        a_wait_resp(0, e, rd, er);
        check("b2b_st_edge", e, 5);
        a_issue(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, acc);
        check("b2b_ld2_acc_in_resp", acc, 1'b1);
        a_wait_resp(0, e, rd, er);
        check("b2b_ld2_edge",  e, 4);
        check("b2b_ld2_rdata", rd, 32'h1111_2222);
        @(negedge clk);
        check("ar_aw_overlap", overlap_cnt, 0);

        // Reset asserted during RD_DATA
        lat = 20;
        a_issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, acc);
        repeat (3) @(negedge clk);
        check("mid_in_rd_data", bus_a.m_axi_rready, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", bus_a.req_ready, 1'b1);
        check("mid_rst_rready",    bus_a.m_axi_rready, 1'b0);
        check("mid_rst_arvalid",   bus_a.m_axi_arvalid, 1'b0);
        check("mid_rst_araddr",    bus_a.m_axi_araddr, 32'h0);
        check("mid_rst_resp",      bus_a.resp_valid, 1'b0);
        check("mid_rst_rdata",     bus_a.resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        base = a_resp_cnt;
        repeat (40) @(negedge clk);
        check("mid_rst_no_stale_resp", a_resp_cnt - base, 0);
        check("mid_rst_ready_after",   bus_a.req_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4_lsu_master.md
# axi4_lsu_master

Single-outstanding AXI4 master bridge between the pipeline's load/store unit and the AXI4 memory slave (data RAM model). It accepts one word-sized load or store request over a valid/ready interface and drives the AR/R or AW/W/B channels. It returns a one-cycle response pulse with read data, or with an error flag if a watchdog expires. It sits directly upstream of the RAM slave; the LSU stalls on `req_ready` low.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: max wait cycles in any channel state before an error response; 8-bit counter.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  LSU request valid
- `req_ready`  out  1  bridge idle, request accepted when both high
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, lane-aligned
- `req_wstrb`  in  4  store byte enables
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  load data, valid with `resp_valid` on loads
- `resp_err`  out  1  watchdog expired, valid with `resp_valid`
- `m_axi_araddr`  out  32
- `m_axi_arvalid`  out  1
- `m_axi_arready`  in  1
- `m_axi_rdata`  in  32
- `m_axi_rvalid`  in  1
- `m_axi_rready`  out  1
- `m_axi_awaddr`  out  32
- `m_axi_awvalid`  out  1
- `m_axi_awready`  in  1
- `m_axi_wdata`  out  32
- `m_axi_wstrb`  out  4
- `m_axi_wvalid`  out  1
- `m_axi_wready`  in  1
- `m_axi_bvalid`  in  1
- `m_axi_bready`  out  1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- `req_ready` = (state == IDLE), combinational. `m_axi_rready` = (state == RD_DATA). `m_axi_bready` = (state == WR_RESP).
- IDLE, load accepted:
  - Latch `{req_addr[31:2],2'b00}` into `m_axi_araddr`.
  - `m_axi_arvalid` <= 1; go to RD_ADDR.
- IDLE, store accepted:
  - Latch the aligned address into `m_axi_awaddr`; latch `req_wdata` and `req_wstrb`.
  - `m_axi_awvalid` <= 1 and `m_axi_wvalid` <= 1; go to WR_REQ.
- RD_ADDR: on `arvalid & arready`, `m_axi_arvalid` <= 0; go to RD_DATA.
- RD_DATA: on `rvalid`, set `resp_rdata` <= `m_axi_rdata` and `resp_valid` <= 1; go to IDLE.
- WR_REQ: AW and W complete independently.
  - Each valid drops on its own handshake and must not be reasserted.
  - Go to WR_RESP once both handshakes are done; they may complete on the same or different edges.
- WR_RESP: on `bvalid`, `resp_valid` <= 1; go to IDLE.
- AXI rule: once asserted, a valid and its payload are held until its ready is sampled high.
- Watchdog:
  - The counter clears on every state change.
  - It increments in each non-IDLE cycle without progress.
  - When it reaches `TIMEOUT_CYCLES`: all m_axi valids <= 0, `resp_valid` <= 1, `resp_err` <= 1, `resp_rdata` <= 0, go to IDLE.
- `resp_err` is 0 on normal completions. `resp_rdata` holds its last value except on timeout.

## Timing
- Reset (async assert, sync-free): state IDLE; every output register and counter is 0. `req_ready` is therefore 1 and `rready`/`bready` are 0.
- Reset mid-transaction abandons it with no response pulse.
- `resp_valid` is high for exactly one cycle.
  - `req_ready` is already 1 in that same cycle, so back-to-back requests are allowed.
  - The next transaction's valids appear one cycle later.
- Against the RAM slave with latency L:
  - Load: `resp_valid` high in the cycle after edge L+3, counting the acceptance edge as edge 0.
  - Store: `resp_valid` high after edge L+4.
- A handshake that completes in the same cycle the watchdog expires counts as progress; no timeout is taken.
- `req_*` inputs are ignored outside IDLE.

## Structure
- Shared package `axi4_bridge_pkg`:
  - state encoding localparams
  - `AXI_ADDR_W` = 32, `AXI_DATA_W` = 32
  - word-alignment mask
- No sub-module. Watchdog and FSM share one always block family; the address/data latches sit in a separate registered block.

## Test plan
- Load with slave L = 20, `mem[4]` = 32'hDEADBEEF, `req_addr` = 32'h10 → one `resp_valid` pulse at edge 23 with `resp_rdata` = 32'hDEADBEEF and `resp_err` = 0.
- Store to 32'h20, `wdata` = 32'hA5A5_1234, `wstrb` = 4'b0011; then load 32'h20 with prior word 0 → load returns 32'h0000_1234; store `resp_valid` at edge 24.
- Slave holds `awready` low 5 cycles while `wready` comes first → `wvalid` drops after its handshake, `awvalid` is held with a stable address, and one response follows the `bvalid` handshake.
- Slave never asserts `arready`, `TIMEOUT_CYCLES` = 10 → `arvalid` drops and `resp_valid` & `resp_err` = 1 at edge 11; the next request is accepted normally.
- Back-to-back load, store, load with `req_valid` held → each is accepted in the `resp_valid` cycle of the previous one, with no overlap of AR and AW valids.
- `rst_n` asserted low during RD_DATA → all outputs 0 immediately; after release `req_ready` = 1 and no stale `resp_valid` appears.
